// File: rtl/pll_phase_seq.sv
// pll_phase_seq: PLL reset/lock sequencer and PSSEL/PSDIR/PSPULSE phase-step controller.
// Clocked from the free-running board clock so it keeps running while the PLL is unlocked.
module pll_phase_seq #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_FILT    = 8,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int PULSE_HIGH   = 4,
  parameter int PULSE_GAP    = 8,
  parameter int STEP_W       = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pll_lock,
  input  logic              relock_req,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_sel,
  input  logic              req_dir,
  input  logic [STEP_W-1:0] req_steps,
  output logic              pll_reset,
  output logic [2:0]        pll_pssel,
  output logic              pll_psdir,
  output logic              pll_pspulse,
  output logic              locked,
  output logic              done,
  output logic              abort,
  output logic              err_timeout
);

  localparam int T_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int T_MAX_B = (PULSE_HIGH > PULSE_GAP) ? PULSE_HIGH : PULSE_GAP;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int TW      = $clog2(T_MAX + 1);
  localparam int FW      = $clog2(LOCK_FILT + 1);

  localparam logic [TW-1:0] RST_LAST  = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] HI_LAST   = TW'(PULSE_HIGH - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(PULSE_GAP - 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILT - 1);

  typedef enum logic [2:0] {
    ST_RST,
    ST_WAIT_LOCK,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE_HI,
    ST_PULSE_GAP
  } state_t;

  state_t              state_reg, state_next;
  logic [TW-1:0]       tmr_reg, tmr_next;
  logic [FW-1:0]       filt_reg, filt_next;
  logic [STEP_W-1:0]   cnt_reg, cnt_next;
  logic [2:0]          sel_reg, sel_next;
  logic                dir_reg, dir_next;
  logic                done_reg, done_next;
  logic                abort_reg, abort_next;
  logic                err_reg, err_next;
  logic [1:0]          sync_reg;
  logic                lock_s;
  logic                busy;

  assign lock_s = sync_reg[1];
  assign busy   = (state_reg == ST_SETUP) || (state_reg == ST_PULSE_HI) ||
                  (state_reg == ST_PULSE_GAP);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= ST_RST;
      tmr_reg   <= '0;
      filt_reg  <= '0;
      cnt_reg   <= '0;
      sel_reg   <= '0;
      dir_reg   <= 1'b0;
      done_reg  <= 1'b0;
      abort_reg <= 1'b0;
      err_reg   <= 1'b0;
      sync_reg  <= '0;
    end else begin
      state_reg <= state_next;
      tmr_reg   <= tmr_next;
      filt_reg  <= filt_next;
      cnt_reg   <= cnt_next;
      sel_reg   <= sel_next;
      dir_reg   <= dir_next;
      done_reg  <= done_next;
      abort_reg <= abort_next;
      err_reg   <= err_next;
      sync_reg  <= {sync_reg[0], pll_lock};
    end
  end

  // tmr_reg is shared: RST length, WAIT_LOCK timeout, and pulse high/gap widths.
  always_comb begin
    state_next = state_reg;
    tmr_next   = tmr_reg;
    filt_next  = filt_reg;
    cnt_next   = cnt_reg;
    sel_next   = sel_reg;
    dir_next   = dir_reg;
    err_next   = err_reg;
    done_next  = 1'b0;
    abort_next = 1'b0;
    if (busy && !lock_s) begin
      // Lock lost mid-request: kill it and restart the PLL.
      state_next = ST_RST;
      tmr_next   = '0;
      abort_next = 1'b1;
    end else begin
      unique case (state_reg)
        ST_RST: begin
          if (tmr_reg == RST_LAST) begin
            state_next = ST_WAIT_LOCK;
            tmr_next   = '0;
            filt_next  = '0;
          end else begin
            tmr_next = tmr_reg + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          filt_next = lock_s ? filt_reg + 1'b1 : '0;
          if (lock_s && (filt_reg == FILT_LAST)) begin
            state_next = ST_IDLE;
            tmr_next   = '0;
            filt_next  = '0;
          end else if (tmr_reg == TMO_LAST) begin
            state_next = ST_RST;
            tmr_next   = '0;
            filt_next  = '0;
            err_next   = 1'b1;
          end else begin
            tmr_next = tmr_reg + 1'b1;
          end
        end
        ST_IDLE: begin
          if (!lock_s) begin
            state_next = ST_RST;
            tmr_next   = '0;
          end else if (req_valid) begin
            sel_next = req_sel;
            dir_next = req_dir;
            cnt_next = req_steps;
            if (req_steps == '0) begin
              done_next = 1'b1;
            end else begin
              state_next = ST_SETUP;
              tmr_next   = '0;
            end
          end else if (relock_req) begin
            state_next = ST_RST;
            tmr_next   = '0;
          end
        end
        ST_SETUP: begin
          state_next = ST_PULSE_HI;
          tmr_next   = '0;
        end
        ST_PULSE_HI: begin
          if (tmr_reg == HI_LAST) begin
            state_next = ST_PULSE_GAP;
            tmr_next   = '0;
            cnt_next   = cnt_reg - 1'b1;
          end else begin
            tmr_next = tmr_reg + 1'b1;
          end
        end
        ST_PULSE_GAP: begin
          if (tmr_reg == GAP_LAST) begin
            tmr_next = '0;
            if (cnt_reg == '0) begin
              state_next = ST_IDLE;
              done_next  = 1'b1;
            end else begin
              state_next = ST_PULSE_HI;
            end
          end else begin
            tmr_next = tmr_reg + 1'b1;
          end
        end
        default: begin
          state_next = ST_RST;
          tmr_next   = '0;
        end
      endcase
    end
  end

  // req_ready is gated by lock_s so a request is never taken in the cycle IDLE is abandoned.
  assign req_ready   = (state_reg == ST_IDLE) && lock_s;
  assign pll_reset   = (state_reg == ST_RST);
  assign pll_pspulse = (state_reg == ST_PULSE_HI);
  assign locked      = (state_reg == ST_IDLE) || busy;
  assign pll_pssel   = sel_reg;
  assign pll_psdir   = dir_reg;
  assign done        = done_reg;
  assign abort       = abort_reg;
  assign err_timeout = err_reg;

endmodule

// File: tb/tb_pll_phase_seq.sv
// Bench for pll_phase_seq: directed table of requests, hand-written lock/reset corner cases,
// and a randomized run compared cycle-by-cycle against a timeline-based reference model.
module tb_pll_phase_seq;

  localparam int RC  = 16;
  localparam int LF  = 8;
  localparam int LT  = 100;
  localparam int PH  = 4;
  localparam int PG  = 8;
  localparam int SW  = 5;
  localparam int PER = PH + PG;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn = 1'b0, pll_lock = 1'b0, relock_req = 1'b0, req_valid = 1'b0;
  logic          req_dir = 1'b0;
  logic [2:0]    req_sel = '0;
  logic [SW-1:0] req_steps = '0;
  logic          req_ready, pll_reset, pll_psdir, pll_pspulse, locked, done, abort, err_timeout;
  logic [2:0]    pll_pssel;

  pll_phase_seq #(
    .RST_CYCLES(RC), .LOCK_FILT(LF), .LOCK_TIMEOUT(LT),
    .PULSE_HIGH(PH), .PULSE_GAP(PG), .STEP_W(SW)
  ) dut (
    .clk(clk), .resetn(resetn), .pll_lock(pll_lock), .relock_req(relock_req),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel), .req_dir(req_dir),
    .req_steps(req_steps), .pll_reset(pll_reset), .pll_pssel(pll_pssel),
    .pll_psdir(pll_psdir), .pll_pspulse(pll_pspulse), .locked(locked), .done(done),
    .abort(abort), .err_timeout(err_timeout)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: mode plus age-in-mode; pulse pattern derived arithmetically from age.
  localparam int M_RST = 0, M_WAIT = 1, M_READY = 2, M_BUSY = 3;
  int       m_mode = M_RST, m_age = 0, m_run = 0, m_steps = 0;
  bit       m_s0 = 0, m_s1 = 0, m_done = 0, m_abort = 0, m_err = 0, m_dir = 0;
  bit [2:0] m_sel = '0;

  function automatic logic [10:0] model_out();
    bit e_pulse;
    e_pulse = (m_mode == M_BUSY) && (m_age >= 1) && (((m_age - 1) % PER) < PH);
    return {m_mode == M_RST, m_sel, m_dir, e_pulse, m_mode >= M_READY,
            (m_mode == M_READY) && m_s1, m_done, m_abort, m_err};
  endfunction

  task automatic model_step();
    bit ls, nd, na;
    if (!resetn) begin
      m_mode = M_RST; m_age = 0; m_run = 0; m_s0 = 0; m_s1 = 0;
      m_sel = '0; m_dir = 0; m_done = 0; m_abort = 0; m_err = 0;
    end else begin
      ls = m_s1; nd = 0; na = 0;
      case (m_mode)
        M_RST: if (m_age == RC - 1) begin m_mode = M_WAIT; m_age = 0; m_run = 0; end
               else m_age++;
        M_WAIT: begin
          m_run = ls ? m_run + 1 : 0;
          if (m_run == LF) begin m_mode = M_READY; m_age = 0; end
          else if (m_age == LT - 1) begin m_mode = M_RST; m_age = 0; m_err = 1; end
          else m_age++;
        end
        M_READY: begin
          if (!ls) begin m_mode = M_RST; m_age = 0; end
          else if (req_valid) begin
            m_sel = req_sel; m_dir = req_dir; m_steps = int'(req_steps);
            if (m_steps == 0) nd = 1;
            else begin m_mode = M_BUSY; m_age = 0; end
          end else if (relock_req) begin m_mode = M_RST; m_age = 0; end
        end
        M_BUSY: begin
          if (!ls) begin m_mode = M_RST; m_age = 0; na = 1; end
          else if (m_age == m_steps * PER) begin m_mode = M_READY; m_age = 0; nd = 1; end
          else m_age++;
        end
        default: ;
      endcase
      m_done = nd; m_abort = na;
      m_s1 = m_s0; m_s0 = pll_lock;
    end
  endtask

  task automatic tick();
    logic [10:0] exp_o, act_o;
    model_step();
    @(posedge clk);
    #1;
    exp_o = model_out();
    act_o = {pll_reset, pll_pssel, pll_psdir, pll_pspulse, locked, req_ready,
             done, abort, err_timeout};
    n_vec++;
    if (act_o !== exp_o) begin
      n_bad++;
      $display("FAIL model cyc=%0d got=%b want=%b", cyc, act_o, exp_o);
    end
    cyc++;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic wait_locked();
    int k;
    k = 0;
    while (!locked && k < 400) begin tick(); k++; end
    check("wait_locked", int'(locked), 1);
  endtask

  task automatic run_req(input int idx, input bit [2:0] sel, input bit dir, input int steps,
                         input bit rl, input int exp_pulses, input int exp_done);
    int pulses, hi_run, low_run, done_at, first_rise, bad_w, ready_busy, rst_seen, sel_bad, aborts;
    bit prev;
    pulses = 0; hi_run = 0; low_run = 0; done_at = -1; first_rise = -1; bad_w = 0;
    ready_busy = 0; rst_seen = 0; sel_bad = 0; aborts = 0; prev = 0;
    check("ready_before_req", int'(req_ready), 1);
    req_valid = 1; req_sel = sel; req_dir = dir; req_steps = SW'(steps); relock_req = rl;
    tick();
    req_valid = 0; relock_req = 0;
    req_sel = 3'($urandom); req_dir = 1'($urandom); req_steps = SW'($urandom);
    for (int k = 1; k < 600 && done_at < 0; k++) begin
      if (pll_pssel !== sel || pll_psdir !== dir) sel_bad++;
      if (pll_reset) rst_seen++;
      if (abort) aborts++;
      if (done) begin
        done_at = k;
        if (steps > 0 && low_run != PG) bad_w++;
      end else begin
        if (req_ready) ready_busy++;
        if (pll_pspulse) begin
          if (!prev) begin
            pulses++;
            if (first_rise < 0) first_rise = k;
            else if (low_run != PG) bad_w++;
            hi_run = 0;
          end
          hi_run++;
          low_run = 0;
        end else begin
          if (prev && hi_run != PH) bad_w++;
          low_run++;
        end
        prev = pll_pspulse;
        tick();
      end
    end
    check("req_pulses", pulses, exp_pulses);
    check("req_first_rise", first_rise, (steps > 0) ? 2 : -1);
    check("req_pulse_widths_bad", bad_w, 0);
    check("req_done_at", done_at, exp_done);
    check("req_ready_while_busy", ready_busy, 0);
    check("req_pll_reset_seen", rst_seen, 0);
    check("req_sel_dir_unstable", sel_bad, 0);
    check("req_abort_seen", aborts, 0);
    $display("req %0d sel=%0d dir=%0d steps=%0d relock=%0d pulses=%0d done_at=%0d",
             idx, sel, dir, steps, rl, pulses, done_at);
  endtask

  typedef struct {
    bit [2:0] sel;
    bit       dir;
    int       steps;
    bit       rl;
    int       pulses;
    int       done_at;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int rst_hi, first_lock, rises, locked_seen, first_err, t_low, aborts, dones, drop_left, k2;
    bit prev_r, prev_p;

    tbl[0] = '{3'd1, 1'b1, 3,  1'b0, 3,  38};
    tbl[1] = '{3'd2, 1'b0, 0,  1'b0, 0,  1};
    tbl[2] = '{3'd2, 1'b0, 2,  1'b0, 2,  26};
    tbl[3] = '{3'd1, 1'b1, 2,  1'b0, 2,  26};
    tbl[4] = '{3'd5, 1'b0, 1,  1'b1, 1,  14};
    tbl[5] = '{3'd7, 1'b1, 31, 1'b0, 31, 374};

    // Power-up: lock_s rises at cycle 40 (pll_lock driven high during cycle 38).
    repeat (3) tick();
    resetn = 1;
    rst_hi = 0; first_lock = -1;
    for (int k = 0; k < 60; k++) begin
      if (pll_reset) rst_hi++;
      if (locked && first_lock < 0) first_lock = k;
      if (k == 38) pll_lock = 1;
      tick();
    end
    check("powerup_reset_cycles", rst_hi, RC);
    check("powerup_lock_cycle", first_lock, 48);
    check("powerup_err_timeout", int'(err_timeout), 0);

    for (int i = 0; i < 6; i++)
      run_req(i, tbl[i].sel, tbl[i].dir, tbl[i].steps, tbl[i].rl, tbl[i].pulses, tbl[i].done_at);

    // Glitchy lock after a relock: never qualifies, times out and retries.
    relock_req = 1;
    tick();
    relock_req = 0;
    rises = 0; locked_seen = 0; first_err = -1; prev_r = 0;
    for (int k = 0; k < 200; k++) begin
      if (pll_reset && !prev_r) rises++;
      prev_r = pll_reset;
      if (locked) locked_seen++;
      if (err_timeout && first_err < 0) first_err = k;
      pll_lock = ((k % 4) != 3);
      tick();
    end
    check("glitch_locked_seen", locked_seen, 0);
    check("glitch_reset_rises", rises, 2);
    check("glitch_first_timeout", first_err, RC + LT);
    pll_lock = 1;
    wait_locked();
    check("err_timeout_sticky", int'(err_timeout), 1);

    // Lock lost during the second of five pulses.
    req_valid = 1; req_sel = 3'd3; req_dir = 0; req_steps = SW'(5);
    tick();
    req_valid = 0;
    rises = 0; prev_p = 0; k2 = 0;
    while (rises < 2 && k2 < 100) begin
      if (pll_pspulse && !prev_p) rises++;
      prev_p = pll_pspulse;
      if (rises < 2) begin tick(); k2++; end
    end
    check("drop_second_pulse_found", rises, 2);
    pll_lock = 0;
    t_low = -1; aborts = 0; dones = 0; rst_hi = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (!pll_pspulse && t_low < 0) t_low = k;
      if (abort) aborts++;
      if (done) dones++;
      if (pll_reset) rst_hi++;
      if (k == 5) pll_lock = 1;
    end
    check("drop_pulse_low_within_3", int'(t_low > 0 && t_low <= 3), 1);
    check("drop_abort_pulses", aborts, 1);
    check("drop_done_pulses", dones, 0);
    check("drop_reset_cycles", rst_hi, RC);
    check("drop_relocked", int'(locked), 1);
    run_req(100, 3'd4, 1'b1, 2, 1'b0, 2, 26);

    // resetn asserted while pspulse is high.
    req_valid = 1; req_sel = 3'd6; req_dir = 1; req_steps = SW'(3);
    tick();
    req_valid = 0;
    k2 = 0;
    while (!pll_pspulse && k2 < 20) begin tick(); k2++; end
    check("midpulse_pulse_high", int'(pll_pspulse), 1);
    resetn = 0;
    tick();
    check("midpulse_reset_outputs",
          int'({pll_reset, pll_pssel, pll_psdir, pll_pspulse, locked, req_ready,
                done, abort, err_timeout}), int'(11'b1_000_0_0_0_0_0_0_0));
    resetn = 1;
    wait_locked();

    // Randomized traffic against the reference model.
    drop_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (drop_left > 0) begin
        drop_left--; pll_lock = 0;
      end else if ($urandom_range(0, 299) == 0) begin
        drop_left = $urandom_range(1, 20); pll_lock = 0;
      end else begin
        pll_lock = 1;
      end
      req_valid  = ($urandom_range(0, 7) == 0);
      req_sel    = 3'($urandom);
      req_dir    = 1'($urandom);
      req_steps  = SW'($urandom_range(0, 4));
      relock_req = ($urandom_range(0, 149) == 0);
      tick();
      if (done || abort)
        $display("rand cyc=%0d sel=%0d dir=%0d done=%0d abort=%0d", cyc, pll_pssel,
                 pll_psdir, done, abort);
    end
    req_valid = 0; relock_req = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
